// File: rtl/cell_select_decoder_if.sv
// Bus between the grid controller (master) and the cell select decoder (slave).
// The controller drives mode/address/strobe requests; the decoder returns the
// registered one-hot select and its status flags.
interface cell_select_decoder_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_CELLS  = 16
);
    logic                  en;
    logic                  mode;
    logic [ADDR_WIDTH-1:0] addr_in;
    logic                  load;
    logic                  step;
    logic                  err_clr;
    logic [NUM_CELLS-1:0]  sel;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_valid;
    logic                  wrap;
    logic                  err;

    modport master (
        output en, mode, addr_in, load, step, err_clr,
        input  sel, sel_addr, sel_valid, wrap, err
    );

    modport slave (
        input  en, mode, addr_in, load, step, err_clr,
        output sel, sel_addr, sel_valid, wrap, err
    );
endinterface

// File: rtl/cell_select_decoder.sv
// Registered one-hot cell select decoder with DIRECT (decode a loaded address)
// and SCAN (auto-stepping, wrapping pointer) modes. All outputs come from
// registers, so every input effect is visible one cycle later.
module cell_select_decoder #(
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_CELLS  = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    cell_select_decoder_if.slave   io_bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_CELLS - 1);
    localparam logic [NUM_CELLS-1:0]  SEL_FIRST = NUM_CELLS'(1);

    state_t                r_state;
    logic [NUM_CELLS-1:0]  r_sel;
    logic [ADDR_WIDTH-1:0] r_sel_addr;
    logic                  r_sel_valid;
    logic                  r_wrap;
    logic                  r_err;

    logic [NUM_CELLS-1:0]  w_dec_in;
    logic [NUM_CELLS-1:0]  w_dec_inc;
    logic [ADDR_WIDTH-1:0] w_addr_inc;
    logic                  w_in_range;
    logic                  w_at_last;
    logic                  w_err_set;

    // Next pointer for a SCAN step; wraps from the last cell back to 0.
    assign w_at_last  = (r_sel_addr == LAST_ADDR);
    assign w_addr_inc = w_at_last ? '0 : r_sel_addr + 1'b1;

    // Per-cell comparators: one-hot decode of the loaded address and of the
    // stepped pointer. An out-of-range address decodes to all zeros.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CELLS; gi++) begin : g_dec
            assign w_dec_in[gi]  = (io_bus.addr_in == ADDR_WIDTH'(gi));
            assign w_dec_inc[gi] = (w_addr_inc     == ADDR_WIDTH'(gi));
        end
    endgenerate

    assign w_in_range = |w_dec_in;
    assign w_err_set  = io_bus.en && io_bus.load && !w_in_range;

    // Mode FSM together with all registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_sel       <= '0;
            r_sel_addr  <= '0;
            r_sel_valid <= 1'b0;
            r_wrap      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_wrap <= 1'b0;

            // Sticky error: a new error wins over a clear in the same cycle.
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (io_bus.err_clr) begin
                r_err <= 1'b0;
            end

            if (!io_bus.en) begin
                r_state     <= ST_IDLE;
                r_sel       <= '0;
                r_sel_valid <= 1'b0;
            end else if (!io_bus.mode) begin
                r_state <= ST_DIRECT;
                if (io_bus.load) begin
                    // Out-of-range loads still report the address so the
                    // controller can see what was rejected.
                    r_sel_addr  <= io_bus.addr_in;
                    r_sel       <= w_dec_in;
                    r_sel_valid <= w_in_range;
                end
            end else begin
                r_state <= ST_SCAN;
                if (io_bus.load && w_in_range) begin
                    // Jump takes priority over both a step and the entry reset.
                    r_sel_addr  <= io_bus.addr_in;
                    r_sel       <= w_dec_in;
                    r_sel_valid <= 1'b1;
                end else if (r_state != ST_SCAN) begin
                    r_sel_addr  <= '0;
                    r_sel       <= SEL_FIRST;
                    r_sel_valid <= 1'b1;
                end else if (io_bus.step && !io_bus.load) begin
                    r_sel_addr  <= w_addr_inc;
                    r_sel       <= w_dec_inc;
                    r_sel_valid <= 1'b1;
                    r_wrap      <= w_at_last;
                end
            end
        end
    end

    assign io_bus.sel       = r_sel;
    assign io_bus.sel_addr  = r_sel_addr;
    assign io_bus.sel_valid = r_sel_valid;
    assign io_bus.wrap      = r_wrap;
    assign io_bus.err       = r_err;
endmodule
